fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the instruction memory (im). Owns the PC, drives
//  the im word address, captures im's combinational read data into a 2-entry fetch
//  queue, presents instructions to decode over a valid/ready handshake and services
//  branch/jump redirects, halt and out-of-range faults. Sits between im and decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  byte address loaded into PC on reset
//  NMEM      128            im depth in words; legal PCs are 0 .. 4*NMEM-4
//  AW        7              im word-index width, clog2(NMEM)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  im_addr      out  32  im word index = {(32-AW)'b0, pc[AW+1:2]}; combinational from pc
//  im_data      in   32  im read data, valid same cycle as im_addr
//  inst_valid   out  1   queue head holds a valid instruction
//  inst_ready   in   1   decode accepts head this cycle
//  inst         out  32  head instruction word
//  inst_pc      out  32  byte PC of head instruction
//  redirect     in   1   load redirect_pc, flush queue
//  redirect_pc  in   32  new byte PC; bits[1:0] must be 0
//  halt         in   1   stop issuing new fetches while high
//  fault        out  1   registered; high in FAULT state
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, queue count=0, state=RUN, fault=0, inst_valid=0,
//   inst=0, inst_pc=0. Reset mid-operation discards queued instructions.
//  States: RUN, HALTED, FAULT. fault=(state==FAULT).
//  pop  = inst_valid & inst_ready.
//  push = (state==RUN) & ~halt & ~redirect & (count<2 | pop).
//  On push: enqueue {pc, im_data}; pc<=pc+4. Fetch latency: instruction enters queue
//   at the edge ending its fetch cycle; inst_valid high the following cycle.
//  Push and pop in the same cycle with count==2: legal, count stays 2.
//  Queue: 2-entry FIFO, in-order; inst/inst_pc/inst_valid taken from head register
//   (no combinational path from im_data or inst_ready to outputs).
//  redirect (highest priority, any state): queue flushed (count<=0), no push, no pop
//   credit; if redirect_pc[1:0]==0 and redirect_pc < 4*NMEM: pc<=redirect_pc,
//   state<=RUN (or HALTED if halt); else state<=FAULT, pc unchanged.
//  Range check: in RUN, if pc >= 4*NMEM at fetch time -> no push, state<=FAULT.
//   pc never wraps; pc+4 past the last word leads to FAULT on next fetch attempt.
//  FAULT: no fetches; queued instructions still drain to decode; exit only via
//   legal redirect or rst.
//  halt: RUN->HALTED when halt & ~redirect; HALTED->RUN when ~halt. Queue drains
//   normally while halted; pc holds.
//  inst_valid may not drop without pop except on redirect or rst; inst/inst_pc
//   stable while inst_valid & ~inst_ready.
// STRUCTURE
//  Shared package (cpu_pkg): state enum {RUN,HALTED,FAULT}, INST_W=32, NOP=32'h0.
//  One sub-module: fetch_fifo2 (2-entry valid/ready FIFO, width 64, clr input).
//  fetch_ctrl holds pc register, state FSM and push/redirect logic.
// TESTING
//  1 im[0..3]=A,B,C,D, RESET_PC=0, inst_ready=1 -> A,B,C,D with inst_pc 0,4,8,C on
//    consecutive cycles; first inst_valid 2 cycles after rst release edge.
//  2 inst_ready=0 for 5 cycles -> count saturates at 2, pc=8, inst=A held stable;
//    ready=1 -> A,B,C in order, no loss or duplication.
//  3 redirect to 0x40 while 2 queued -> queue flushed next cycle, next inst_pc=0x40,
//    inst=im[16]; flushed entries never appear.
//  4 redirect_pc=0x42, then redirect_pc=0x200 (NMEM=128) -> fault=1 each time, pc
//    unchanged; legal redirect 0x10 -> fault=0, fetch resumes at im[4].
//  5 sequential run to pc=0x1FC then 0x200 -> im[127] delivered, fault=1, no further
//    pushes, queue drains.
//  6 halt pulse 3 cycles mid-stream; rst asserted with count=2 -> pc holds during
//    halt, resumes in order; after rst inst_valid=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // One fetch-queue entry: byte PC plus the instruction word read at it
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry in-order fetch queue; outputs come straight from the head register.
module fetch_fifo2
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output logic         valid,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t head;
    fetch_entry_t tail;
    logic [1:0]   cnt;
    logic         push_ok;
    logic         pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves
    assign pop_ok  = pop & (cnt != 2'd0);
    assign push_ok = push & ((cnt != 2'd2) | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '{pc: '0, inst: NOP};
            tail <= '{pc: '0, inst: NOP};
            cnt  <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign dout  = head;
    assign count = cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, feeds a 2-entry queue from im and
// services redirects, halt and out-of-range faults.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NMEM     = 128,
    parameter int unsigned AW       = 7
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fault
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * NMEM);

    state_t       state;
    state_t       state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [1:0]   count;
    logic         pop;
    logic         push;
    logic         pc_ok;
    logic         redirect_ok;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign im_addr = {{(32-AW){1'b0}}, pc[AW+1:2]};

    // A redirect flushes the queue, so the head is not credited as consumed
    assign pop         = inst_valid & inst_ready & ~redirect;
    assign pc_ok       = (pc < PC_LIMIT);
    assign redirect_ok = (redirect_pc[1:0] == 2'b00) & (redirect_pc < PC_LIMIT);
    assign push        = (state == RUN) & ~halt & ~redirect & pc_ok &
                         ((count != 2'd2) | pop);
    assign push_entry  = '{pc: pc, inst: im_data};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect) begin
            if (redirect_ok) begin
                pc_next    = redirect_pc;
                state_next = halt ? HALTED : RUN;
            end else begin
                state_next = FAULT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (halt)        state_next = HALTED;
                    else if (!pc_ok) state_next = FAULT;
                    else if (push)   pc_next    = pc + 32'd4;
                end
                HALTED: begin
                    if (!halt) state_next = RUN;
                end
                FAULT: begin
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            fault <= (state_next == FAULT);
        end
    end

    fetch_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .valid (inst_valid),
        .dout  (head),
        .count (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule
